// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_ctrl_pkg;

  // Default register address width; the file holds 2**ADDR_W_DEF entries.
  localparam int ADDR_W_DEF = 3;

  // Default data width of each register.
  localparam int N_DEF = 8;

  // Highest register index for the default address width; the clear ends here.
  localparam int LAST_REG = 2**ADDR_W_DEF - 1;

  // RUN: requesters share the port. CLEAR: the port walks registers 1..LAST.
  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_wport_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. Grants the single valid requester, or on a tie
// the one that was not granted last. The last-grant memory moves only when a
// grant is actually taken (accept), so a stalled tie keeps its winner.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last; reset value lets requester 0 win the first tie.
  logic last_grant;

  // Combinational grant selection from the valid lines and the last-grant memory.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Remember which requester was served; only updated on a completed handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/regfile_wport_ctrl.sv
// Write-port controller for the register file. Shares the single write port
// (wa3/wd3/we3) between two writeback requesters and runs a clear sequence
// that zeros registers 1..2**ADDR_W-1. Writes to register 0 are accepted but
// never reach the port.
//
// Handshake: a write is transferred on a rising edge where valid && ready.
// Ready is combinational, asserted only in RUN, with clr_start low, and when
// the arbiter grants that requester; it never waits for valid to drop. A
// requester keeps valid/addr/data stable until it sees the transfer.
module regfile_wport_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [N-1:0]      req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [N-1:0]      req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] wa3,
  output logic [N-1:0]      wd3,
  output logic              we3
);

  // Last register written by the clear walk; the walk starts at 1 and stops here.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(2**ADDR_W - 1);

  state_t            state;
  state_t            state_n;
  logic [1:0]        grant;
  logic              acc0;
  logic              acc1;
  logic              we3_n;
  logic [ADDR_W-1:0] wa3_n;
  logic [N-1:0]      wd3_n;
  logic              clr_done_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .accept (acc0 | acc1),
    .grant  (grant)
  );

  // Ready/accept: a pending clear request takes the port ahead of any writer.
  always_comb begin
    req0_ready = (state == RUN) && !clr_start && grant[0];
    req1_ready = (state == RUN) && !clr_start && grant[1];
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
  end

  assign clr_busy = (state == CLEAR);

  // Next state and next port values. wa3 doubles as the clear walk counter.
  always_comb begin
    state_n    = state;
    we3_n      = 1'b0;
    wa3_n      = wa3;
    wd3_n      = wd3;
    clr_done_n = 1'b0;
    case (state)
      RUN: begin
        if (clr_start) begin
          state_n = CLEAR;
          we3_n   = 1'b1;
          wa3_n   = ADDR_W'(1);
          wd3_n   = '0;
        end else if (acc0) begin
          we3_n = (req0_addr != '0);
          wa3_n = req0_addr;
          wd3_n = req0_data;
        end else if (acc1) begin
          we3_n = (req1_addr != '0);
          wa3_n = req1_addr;
          wd3_n = req1_data;
        end
      end
      CLEAR: begin
        if (wa3 == LAST_ADDR) begin
          state_n    = RUN;
          clr_done_n = 1'b1;
        end else begin
          we3_n = 1'b1;
          wa3_n = wa3 + ADDR_W'(1);
          wd3_n = '0;
        end
      end
      default: state_n = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  // Registered write port and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3      <= 1'b0;
      wa3      <= '0;
      wd3      <= '0;
      clr_done <= 1'b0;
    end else begin
      we3      <= we3_n;
      wa3      <= wa3_n;
      wd3      <= wd3_n;
      clr_done <= clr_done_n;
    end
  end

endmodule
